// File: rtl/tri_nand3_stim_checker.sv
// Stimulus sequencer and result checker for a 74LS10 triple 3-input NAND model.
// Sweeps 22 vectors, holds each for SETTLE_CYCLES, then checks Y1..Y3 against the NAND of the drive.
module tri_nand3_stim_checker #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned ERR_W         = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             A1,
  output logic             B1,
  output logic             C1,
  output logic             A2,
  output logic             B2,
  output logic             C2,
  output logic             A3,
  output logic             B3,
  output logic             C3,
  input  logic             Y1,
  input  logic             Y2,
  input  logic             Y3,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [4:0]       fail_idx,
  output logic [2:0]       fail_mask,
  output logic             fail_valid
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [4:0]     LAST_IDX = 5'd21;
  localparam logic [7:0]     CNT_INIT = 8'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W:0] ERR_MAX  = {1'b0, {ERR_W{1'b1}}};

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [4:0]       idx_q, idx_d;
  logic [8:0]       stim_q, stim_d;   // {A1,B1,C1,A2,B2,C2,A3,B3,C3}
  logic [ERR_W-1:0] err_q, err_d;
  logic [4:0]       fidx_q, fidx_d;
  logic [2:0]       fmask_q, fmask_d;
  logic             fv_q, fv_d;
  logic [2:0]       exp_y, mism;
  logic [ERR_W:0]   err_sum;

  // Gates are stepped in order; earlier gates sit at 111 while a later one counts 001..111.
  function automatic logic [8:0] vec_at(input logic [4:0] i);
    logic [8:0] v;
    logic [4:0] t;
    v = '0;
    t = '0;
    if (i == 5'd0) begin
      v = '0;
    end else if (i <= 5'd7) begin
      v[8:6] = i[2:0];
    end else if (i <= 5'd14) begin
      t      = i - 5'd7;
      v[8:6] = '1;
      v[5:3] = t[2:0];
    end else begin
      t      = i - 5'd14;
      v[8:6] = '1;
      v[5:3] = '1;
      v[2:0] = t[2:0];
    end
    return v;
  endfunction

  always_comb begin
    exp_y   = {~&stim_q[2:0], ~&stim_q[5:3], ~&stim_q[8:6]};
    mism    = {Y3, Y2, Y1} ^ exp_y;
    err_sum = {1'b0, err_q} + {{ERR_W{1'b0}}, mism[0]}
            + {{ERR_W{1'b0}}, mism[1]} + {{ERR_W{1'b0}}, mism[2]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stim_d  = stim_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    fmask_d = fmask_q;
    fv_d    = fv_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          idx_d   = '0;
          stim_d  = vec_at(5'd0);
          cnt_d   = CNT_INIT;
          err_d   = '0;
          fidx_d  = '0;
          fmask_d = '0;
          fv_d    = 1'b0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 8'd0) state_d = CHECK;
        else               cnt_d   = cnt_q - 8'd1;
      end
      CHECK: begin
        err_d = (err_sum > ERR_MAX) ? ERR_MAX[ERR_W-1:0] : err_sum[ERR_W-1:0];
        if ((mism != 3'b000) && !fv_q) begin
          fidx_d  = idx_q;
          fmask_d = mism;
          fv_d    = 1'b1;
        end
        // The next vector is driven on the same edge that samples this one.
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 5'd1;
          stim_d  = vec_at(idx_q + 5'd1);
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      stim_q  <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fmask_q <= '0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stim_q  <= stim_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fmask_q <= fmask_d;
      fv_q    <= fv_d;
    end
  end

  assign {A1, B1, C1, A2, B2, C2, A3, B3, C3} = stim_q;
  assign busy       = (state_q == SETTLE) || (state_q == CHECK);
  assign done       = (state_q == DONE);
  assign pass       = done && (err_q == '0);
  assign err_count  = err_q;
  assign fail_idx   = fidx_q;
  assign fail_mask  = fmask_q;
  assign fail_valid = fv_q;

endmodule

// File: tb/tb_tri_nand3_stim_checker.sv
// Bench for tri_nand3_stim_checker: gate-model environment with fault injection,
// checked against a sweep-level reference model.
module tb_tri_nand3_stim_checker;

  localparam int S    = 4;
  localparam int EW   = 5;
  localparam int NVEC = 22;

  logic clk = 1'b0;
  logic reset;
  logic start;
  always #5 clk = ~clk;

  // main instance (SETTLE_CYCLES=4)
  logic a1, b1, c1, a2, b2, c2, a3, b3, c3;
  logic [2:0] y_main;
  logic busy, done, pass, fail_valid;
  logic [EW-1:0] err_count;
  logic [4:0] fail_idx;
  logic [2:0] fail_mask;

  // short-settle instance (SETTLE_CYCLES=1), always driven by the delayed gate model
  logic s_a1, s_b1, s_c1, s_a2, s_b2, s_c2, s_a3, s_b3, s_c3;
  logic [2:0] y_short;
  logic s_busy, s_done, s_pass, s_fail_valid;
  logic [EW-1:0] s_err_count;
  logic [4:0] s_fail_idx;
  logic [2:0] s_fail_mask;

  tri_nand3_stim_checker #(.SETTLE_CYCLES(S), .ERR_W(EW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .A1(a1), .B1(b1), .C1(c1), .A2(a2), .B2(b2), .C2(c2), .A3(a3), .B3(b3), .C3(c3),
    .Y1(y_main[0]), .Y2(y_main[1]), .Y3(y_main[2]),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_idx(fail_idx), .fail_mask(fail_mask), .fail_valid(fail_valid)
  );

  tri_nand3_stim_checker #(.SETTLE_CYCLES(1), .ERR_W(EW)) dut_short (
    .clk(clk), .reset(reset), .start(start),
    .A1(s_a1), .B1(s_b1), .C1(s_c1), .A2(s_a2), .B2(s_b2), .C2(s_c2),
    .A3(s_a3), .B3(s_b3), .C3(s_c3),
    .Y1(y_short[0]), .Y2(y_short[1]), .Y3(y_short[2]),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err_count),
    .fail_idx(s_fail_idx), .fail_mask(s_fail_mask), .fail_valid(s_fail_valid)
  );

  logic [8:0] stim, s_stim;
  assign stim   = {a1, b1, c1, a2, b2, c2, a3, b3, c3};
  assign s_stim = {s_a1, s_b1, s_c1, s_a2, s_b2, s_c2, s_a3, s_b3, s_c3};

  // environment: 0 golden, 1 Y1 stuck 1, 2 all stuck 0, 3 golden delayed 25ns, 4 random flips
  int unsigned mode;
  logic [8:0]  tbl  [NVEC];
  logic [2:0]  flip [NVEC];
  logic [2:0]  y_del, s_y_del;

  function automatic logic [2:0] nand3x(input logic [8:0] s);
    return {~(s[2] & s[1] & s[0]), ~(s[5] & s[4] & s[3]), ~(s[8] & s[7] & s[6])};
  endfunction

  function automatic int idx_of(input logic [8:0] s);
    for (int i = 0; i < NVEC; i++) if (tbl[i] == s) return i;
    return -1;
  endfunction

  function automatic logic [2:0] env_y(input int unsigned m, input logic [8:0] s, input int i);
    logic [2:0] g;
    g = nand3x(s);
    case (m)
      1: return g | 3'b001;
      2: return 3'b000;
      4: return (i >= 0) ? (g ^ flip[i]) : g;
      default: return g;
    endcase
  endfunction

  always @(stim)   y_del   <= #25 nand3x(stim);
  always @(s_stim) s_y_del <= #25 nand3x(s_stim);
  assign y_short = s_y_del;
  always_comb begin
    y_main = nand3x(stim);
    if (mode == 3) y_main = y_del;
    else           y_main = env_y(mode, stim, idx_of(stim));
  end

  int checks = 0;
  int errors = 0;

  // reference results for one sweep under the current environment
  int   exp_err, exp_fidx, exp_fmask;
  bit   exp_fv;
  task automatic model_sweep();
    int total;
    logic [2:0] mm;
    total = 0; exp_fv = 0; exp_fidx = 0; exp_fmask = 0;
    for (int i = 0; i < NVEC; i++) begin
      mm = nand3x(tbl[i]) ^ env_y((mode == 3) ? 0 : mode, tbl[i], i);
      total += $countones(mm);
      if (mm != 0 && !exp_fv) begin
        exp_fv = 1; exp_fidx = i; exp_fmask = int'(mm);
      end
    end
    exp_err = (total > (1 << EW) - 1) ? (1 << EW) - 1 : total;
  endtask

  // observations of one sweep
  int obs_cycles, obs_busy, obs_stim_bad;
  logic ps_done, ps_busy, ps_fv;
  logic [EW-1:0] ps_err;
  logic [4:0] ps_fidx;
  logic [2:0] ps_fmask;

  task automatic run_sweep(input int repulse_at);
    int vi;
    obs_cycles = -1; obs_busy = 0; obs_stim_bad = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    ps_done = done; ps_busy = busy; ps_fv = fail_valid;
    ps_err = err_count; ps_fidx = fail_idx; ps_fmask = fail_mask;
    if (busy) obs_busy++;
    if (stim !== tbl[0]) obs_stim_bad++;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk); start = (c == repulse_at);
      @(posedge clk); #1;
      vi = c / (S + 1);
      if (vi > NVEC - 1) vi = NVEC - 1;
      if (stim !== tbl[vi]) obs_stim_bad++;
      if (done) begin
        obs_cycles = c;
        break;
      end
      if (busy) obs_busy++;
    end
    @(negedge clk); start = 1'b0;
  endtask

  task automatic check_results(input string tag);
    model_sweep();
    checks++;
    if (obs_cycles !== 22 * (S + 1)) begin
      errors++; $display("FAIL %s done_latency got %0d want %0d", tag, obs_cycles, 22 * (S + 1));
    end
    checks++;
    if (obs_busy !== 22 * (S + 1)) begin
      errors++; $display("FAIL %s busy_cycles got %0d want %0d", tag, obs_busy, 22 * (S + 1));
    end
    checks++;
    if (obs_stim_bad !== 0) begin
      errors++; $display("FAIL %s stim_sequence got %0d bad cycles want 0", tag, obs_stim_bad);
    end
    checks++;
    if (err_count !== EW'(exp_err)) begin
      errors++; $display("FAIL %s err_count got %0d want %0d", tag, err_count, exp_err);
    end
    checks++;
    if (pass !== (exp_err == 0)) begin
      errors++; $display("FAIL %s pass got %0b want %0b", tag, pass, exp_err == 0);
    end
    checks++;
    if (fail_valid !== exp_fv || fail_idx !== 5'(exp_fidx) || fail_mask !== 3'(exp_fmask)) begin
      errors++;
      $display("FAIL %s first_fail got v%0b idx%0d mask%03b want v%0b idx%0d mask%03b",
               tag, fail_valid, fail_idx, fail_mask, exp_fv, exp_fidx, exp_fmask[2:0]);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_at_done got %0b want 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({stim, busy, done, pass, err_count, fail_valid, fail_idx, fail_mask} !== '0) begin
      errors++;
      $display("FAIL reset_state got stim=%09b busy=%0b done=%0b pass=%0b err=%0d fv=%0b want all 0",
               stim, busy, done, pass, err_count, fail_valid);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle_no_start got busy=%0b done=%0b want 0 0", busy, done);
    end
  endtask

  task automatic test_golden();
    mode = 0;
    run_sweep(-1);
    checks++;
    if (ps_busy !== 1'b1 || ps_done !== 1'b0) begin
      errors++; $display("FAIL golden_start got busy=%0b done=%0b want 1 0", ps_busy, ps_done);
    end
    check_results("golden");
  endtask

  task automatic test_stuck_faults();
    mode = 1;
    run_sweep(-1);
    check_results("y1_stuck1");
    checks++;
    if (err_count !== 5'd15 || fail_idx !== 5'd7 || fail_mask !== 3'b001) begin
      errors++; $display("FAIL y1_stuck1_const got err=%0d idx=%0d mask=%03b want 15 7 001",
                         err_count, fail_idx, fail_mask);
    end
    mode = 2;
    run_sweep(-1);
    check_results("all_stuck0");
    checks++;
    if (err_count !== 5'd31 || fail_idx !== 5'd0 || fail_mask !== 3'b111) begin
      errors++; $display("FAIL saturate_const got err=%0d idx=%0d mask=%03b want 31 0 111",
                         err_count, fail_idx, fail_mask);
    end
  endtask

  task automatic test_random_faults();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NVEC; i++)
        flip[i] = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
      mode = 4;
      run_sweep(-1);
      check_results($sformatf("random%0d", r));
    end
    for (int i = 0; i < NVEC; i++) flip[i] = 3'b000;
  endtask

  task automatic test_delay();
    mode = 3;
    run_sweep(-1);
    check_results("delay_settle4");
    checks++;
    if (s_done !== 1'b1 || s_pass !== 1'b0 || s_err_count == '0) begin
      errors++; $display("FAIL delay_settle1 got done=%0b pass=%0b err=%0d want 1 0 >0",
                         s_done, s_pass, s_err_count);
    end
  endtask

  task automatic test_reset_mid();
    mode = 2;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (36) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({stim, busy, done, pass, err_count, fail_valid, fail_idx, fail_mask} !== '0) begin
      errors++; $display("FAIL reset_mid_async got stim=%09b busy=%0b err=%0d fv=%0b want all 0",
                         stim, busy, err_count, fail_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({stim, busy, done, pass, err_count, fail_valid} !== '0) begin
      errors++; $display("FAIL reset_mid_next got stim=%09b busy=%0b done=%0b err=%0d want all 0",
                         stim, busy, done, err_count);
    end
    @(negedge clk); reset = 1'b0;
    mode = 0;
    run_sweep(-1);
    check_results("after_reset");
  endtask

  task automatic test_back_to_back();
    mode = 1;
    run_sweep(50);
    check_results("repulse_busy");
    mode = 0;
    run_sweep(-1);
    checks++;
    if (ps_done !== 1'b0 || ps_busy !== 1'b1 || ps_err !== '0 || ps_fv !== 1'b0
        || ps_fidx !== '0 || ps_fmask !== '0) begin
      errors++;
      $display("FAIL restart_clear got done=%0b busy=%0b err=%0d fv=%0b idx=%0d mask=%03b want 0 1 0 0 0 000",
               ps_done, ps_busy, ps_err, ps_fv, ps_fidx, ps_fmask);
    end
    check_results("restart");
  endtask

  initial begin
    int n;
    n = 0;
    tbl[n++] = 9'b0;
    for (int g = 0; g < 3; g++)
      for (int v = 1; v <= 7; v++) begin
        logic [8:0] w;
        w = 9'b0;
        for (int k = 0; k < g; k++) w[8 - 3 * k -: 3] = 3'b111;
        w[8 - 3 * g -: 3] = 3'(v);
        tbl[n++] = w;
      end
    for (int i = 0; i < NVEC; i++) flip[i] = 3'b000;

    test_reset();
    test_golden();
    test_stuck_faults();
    test_random_faults();
    test_delay();
    test_reset_mid();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tri_nand3_stim_checker.md
# tri_nand3_stim_checker

Self-checking stimulus sequencer that sits directly upstream of the 74LS10 triple 3-input NAND model. It drives the nine gate inputs through a fixed 22-vector sweep: all-zero first, then gate 1, gate 2 and gate 3 each stepped 001..111 in turn, with earlier gates held at 111. Each vector is held for a programmable settle time, then Y1..Y3 are sampled and compared against the NAND of the driven inputs. The block reports pass/fail, a saturating mismatch count and first-failure capture, so the gate model can be exercised on hardware or in a clocked bench.

## Interface
- SETTLE_CYCLES, 4, cycles each vector is held before sampling; legal range 1..255
- ERR_W, 5, width of err_count
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begins a sweep; sampled only in IDLE or DONE
- A1,B1,C1,A2,B2,C2,A3,B3,C3  out  1 each  stimulus to the NAND gates (registered)
- Y1,Y2,Y3  in  1 each  gate outputs under test
- busy  out  1  high while a sweep is running
- done  out  1  level; high from sweep completion until the next accepted start
- pass  out  1  done && err_count==0
- err_count  out  ERR_W  total per-gate mismatches, saturating at 2^ERR_W-1
- fail_idx  out  5  vector index of the first mismatching vector
- fail_mask  out  3  {gate3,gate2,gate1} mismatch bits at fail_idx
- fail_valid  out  1  first-failure fields are valid

## Operation
- Vector table, index 0..21, triple listed as {A,B,C}:
  - idx 0: all gates 000.
  - idx 1..7: gate1 = idx (001..111); gates 2 and 3 are 000.
  - idx 8..14: gate1 111; gate2 = idx-7; gate3 000.
  - idx 15..21: gates 1 and 2 111; gate3 = idx-14.
- Expected Yn = ~(An & Bn & Cn), computed from the registered stimulus.
- FSM states: IDLE, SETTLE, CHECK, DONE.
  - IDLE/DONE with start=1:
    - Load vector 0 and cnt = SETTLE_CYCLES-1.
    - Clear err_count, fail_valid, fail_idx and fail_mask.
    - Go to SETTLE.
  - SETTLE: if cnt==0, go to CHECK; otherwise decrement cnt.
  - CHECK: compare {Y3,Y2,Y1} with the expected value.
    - err_count += popcount(mismatch), saturating.
    - If mismatch is nonzero and fail_valid=0: capture idx and mask, set fail_valid.
    - If idx==21, go to DONE; otherwise load the next vector, reload cnt and go to SETTLE.
  - DONE: hold the stimulus at the last vector (all 111). Results stay stable.
- busy = state is SETTLE or CHECK. done = state is DONE.
- start is ignored while busy. A start in DONE restarts the sweep and drops done.
- Reset (any time, including mid-sweep): state IDLE, all stimulus outputs 0, all status outputs 0. The sweep aborts with no partial result retained.

## Timing
- Accepted start at edge k:
  - Stimulus for idx 0 is valid after edge k.
  - SETTLE occupies SETTLE_CYCLES cycles.
  - Y is sampled at edge k+SETTLE_CYCLES+1, which is (SETTLE_CYCLES+1) clock periods after the drive.
- Per vector: SETTLE_CYCLES+1 cycles. The next vector is driven on the same edge that samples the current one.
- done rises at edge k + 22·(SETTLE_CYCLES+1). Default: k+110.
- err_count, fail_* and pass are stable whenever done=1.

## Test plan
- Golden NAND model (zero delay), SETTLE_CYCLES=4, start pulse → done at start+110 cycles, busy high for 110 cycles, err_count=0, pass=1, fail_valid=0. The stimulus sequence matches the table exactly.
- Y1 forced to 1, other outputs golden → mismatches only when gate1=111 (idx 7..21). Result: err_count=15, fail_idx=7, fail_mask=001, pass=0.
- Y1..Y3 all forced to 0, ERR_W=5 → 42 raw mismatches saturate to err_count=31. fail_idx=0, fail_mask=111.
- Golden model with 25 ns output delay, 10 ns clock → SETTLE_CYCLES=4 gives pass=1. SETTLE_CYCLES=1 gives sampling 20 ns after drive, so pass=0 and err_count>0.
- Reset asserted at start+37 → next cycle all outputs 0 and state IDLE. A new start then completes a clean sweep with pass=1.
- start re-pulsed at start+50 while busy → ignored; done still at start+110. A start pulse while done=1 clears results and drops done on the next cycle.
